// File: rtl/tt_um_alvin_asmar_flop_bank.sv
// Multi-channel storage-element bank: gated-D, toggle, enable-edge capture or shift chain
// per a global mode, with synchronised inputs and a saturating output-change counter.
module tt_um_alvin_asmar_flop_bank #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic [1:0] {
        MODE_GATED_D = 2'b00,
        MODE_TOGGLE  = 2'b01,
        MODE_EDGE    = 2'b10,
        MODE_SHIFT   = 2'b11
    } mode_e;

    localparam int SW = 2 * WIDTH + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [SW-1:0]    raw_in;
    logic [SW-1:0]    sync_out;
    logic [WIDTH-1:0] ds;
    logic [WIDTH-1:0] es;
    mode_e            mode_s;
    logic             frz_s;
    logic             clr_s;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] e_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [WIDTH-1:0] next_gated;
    logic [WIDTH-1:0] next_toggle;
    logic [WIDTH-1:0] next_edge;
    logic [WIDTH-1:0] next_shift;
    logic             changed;

    // Only the used pins are carried through the synchroniser, packed as one bus.
    assign raw_in = {uio_in[3:0], ui_in[4+WIDTH-1:4], ui_in[WIDTH-1:0]};

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync_out = raw_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][SW-1:0] stage_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q[0] <= raw_in;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        stage_q[k] <= stage_q[k-1];
                    end
                end
            end

            assign sync_out = stage_q[SYNC_STAGES-1];
        end
    endgenerate

    assign ds     = sync_out[WIDTH-1:0];
    assign es     = sync_out[2*WIDTH-1:WIDTH];
    assign mode_s = mode_e'(sync_out[2*WIDTH+1:2*WIDTH]);
    assign frz_s  = sync_out[2*WIDTH+2];
    assign clr_s  = sync_out[2*WIDTH+3];

    // Candidate next value of every channel for each mode; the mode mux picks one.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            assign next_gated[gi]  = es[gi] ? ds[gi] : q_q[gi];
            assign next_toggle[gi] = q_q[gi] ^ (es[gi] & ds[gi]);
            assign next_edge[gi]   = (es[gi] & ~e_prev_q[gi]) ? ds[gi] : q_q[gi];

            if (gi == 0) begin : g_shift_head
                assign next_shift[gi] = es[0] ? ds[0] : q_q[gi];
            end else begin : g_shift_body
                assign next_shift[gi] = es[0] ? q_q[gi-1] : q_q[gi];
            end
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (!frz_s) begin
            case (mode_s)
                MODE_GATED_D: q_d = next_gated;
                MODE_TOGGLE:  q_d = next_toggle;
                MODE_EDGE:    q_d = next_edge;
                MODE_SHIFT:   q_d = next_shift;
                default:      q_d = q_q;
            endcase
        end
    end

    assign changed = (q_d != q_q);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_s) begin
            cnt_d = '0;
        end else if (changed && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // e_prev tracks the synced enables even while frozen, so edges seen during freeze are lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q      <= '0;
            e_prev_q <= '0;
            cnt_q    <= '0;
        end else begin
            q_q      <= q_d;
            e_prev_q <= es;
            cnt_q    <= cnt_d;
        end
    end

    logic [3:0] q_ext;
    logic [3:0] cnt_ext;

    always_comb begin
        q_ext                 = '0;
        q_ext[WIDTH-1:0]      = q_q;
        cnt_ext               = '0;
        cnt_ext[CNT_W-1:0]    = cnt_q;
    end

    assign uo_out  = {cnt_ext, q_ext};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic _unused;
    assign _unused = &{1'b0, ena, ui_in, uio_in[7:4]};

endmodule
